// File: rtl/conv_mask_sched_if.sv
// conv_mask_sched_if
//   Groups the request handshakes, the shared datapath issue/result pins, the
//   two result streams and the busy flag of conv_mask_sched.
//   slave  : the scheduler side (accepts windows, drives the datapath, sources results)
//   master : the environment side (requesters, datapath, result consumers)
interface conv_mask_sched_if #(
    parameter int DW = 16
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req1_valid;
    logic          req1_ready;
    logic          dp_en;
    logic          dp_sel;
    logic [DW-1:0] dp_dout;
    logic          out0_valid;
    logic          out0_ready;
    logic [DW-1:0] out0_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [DW-1:0] out1_data;
    logic          busy;

    modport slave (
        input  req0_valid, req1_valid, dp_dout, out0_ready, out1_ready,
        output req0_ready, req1_ready, dp_en, dp_sel,
               out0_valid, out0_data, out1_valid, out1_data, busy
    );

    modport master (
        output req0_valid, req1_valid, dp_dout, out0_ready, out1_ready,
        input  req0_ready, req1_ready, dp_en, dp_sel,
               out0_valid, out0_data, out1_valid, out1_data, busy
    );
endinterface

// File: rtl/conv_mask_sched.sv
// conv_mask_sched
//   Shares one free-running LAT-stage mask datapath between two requesters.
//   A round-robin arbiter issues at most one window per cycle, a LAT-deep
//   valid/sel shift register tracks issues, and each result is steered into
//   a per-requester first-word-fall-through FIFO of DEPTH entries.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : synchronous active-low reset
//   cfg_en   : 1 = issue allowed, 0 = freeze issue while in-flight results drain
//   bus      : conv_mask_sched_if.slave
//              req0/req1 valid/ready  window handshakes (ready = grant)
//              dp_en/dp_sel           issue strobe and operand select
//              dp_dout                datapath result, valid LAT cycles after issue
//              out0/out1 valid/ready/data  result streams
//              busy                   registered: anything in flight or buffered
//
// Timing: an issue in cycle t has its result on dp_dout in cycle t+LAT, where
// it is pushed into its FIFO. An empty FIFO shows the arriving result
// combinationally, so a consumer that never stalls sees it in cycle t+LAT and
// the FIFO count stays at zero. This is what lets a single requester sustain
// one issue per cycle under the credit rule below.
module conv_mask_sched #(
    parameter int DW    = 16,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    conv_mask_sched_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LAT + 1);

    logic [LAT-1:0] sr_valid_q, sr_valid_d;
    logic [LAT-1:0] sr_sel_q, sr_sel_d;
    logic [PW-1:0]  wr_ptr_q [2];
    logic [PW-1:0]  wr_ptr_d [2];
    logic [PW-1:0]  rd_ptr_q [2];
    logic [PW-1:0]  rd_ptr_d [2];
    logic [CW-1:0]  count_q  [2];
    logic [CW-1:0]  count_d  [2];
    logic [DW-1:0]  mem_q    [2][DEPTH];
    logic [DW-1:0]  mem_d    [2][DEPTH];
    logic           rr_last_q, rr_last_d;
    logic           dp_sel_q, dp_sel_d;
    logic           busy_q, busy_d;

    logic [IW-1:0]  inflight [2];
    logic [DW-1:0]  head     [2];
    logic [1:0]     req_valid;
    logic [1:0]     out_ready;
    logic [1:0]     elig;
    logic [1:0]     gnt;
    logic [1:0]     push_vec;
    logic [1:0]     nonempty;
    logic [1:0]     pop;
    logic           issue;
    logic           gnt_sel;
    logic           push;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign out_ready = {bus.out1_ready, bus.out0_ready};

    // Number of in-flight results owned by each requester.
    always_comb begin
        inflight[0] = '0;
        inflight[1] = '0;
        for (int i = 0; i < LAT; i++) begin
            if (sr_valid_q[i]) begin
                if (sr_sel_q[i]) inflight[1] = inflight[1] + 1'b1;
                else             inflight[0] = inflight[0] + 1'b1;
            end
        end
    end

    // Credit uses registered counts only, so a pop frees a slot one cycle later.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            elig[n] = rst_n & cfg_en & req_valid[n] &
                      ((int'(count_q[n]) + int'(inflight[n])) < DEPTH);
        end
    end

    // rr_last_q holds the index granted most recently; on a tie the other wins.
    always_comb begin
        issue   = |elig;
        gnt_sel = (elig[0] & elig[1]) ? ~rr_last_q : elig[1];
        gnt     = 2'b00;
        if (issue) gnt = gnt_sel ? 2'b10 : 2'b01;
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.dp_en      = issue;
    assign bus.dp_sel     = issue ? gnt_sel : dp_sel_q;

    assign push     = sr_valid_q[LAT-1];
    assign push_vec = {push & sr_sel_q[LAT-1], push & ~sr_sel_q[LAT-1]};

    // First-word fall-through with bypass of a result arriving at an empty FIFO.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            nonempty[n] = rst_n & ((count_q[n] != '0) | push_vec[n]);
            head[n]     = (count_q[n] == '0) ? bus.dp_dout : mem_q[n][rd_ptr_q[n]];
            pop[n]      = nonempty[n] & out_ready[n];
        end
    end

    assign bus.out0_valid = nonempty[0];
    assign bus.out0_data  = head[0];
    assign bus.out1_valid = nonempty[1];
    assign bus.out1_data  = head[1];
    assign bus.busy       = busy_q;

    always_comb begin
        sr_valid_d    = '0;
        sr_sel_d      = '0;
        sr_valid_d[0] = issue;
        sr_sel_d[0]   = gnt_sel;
        for (int i = 1; i < LAT; i++) begin
            sr_valid_d[i] = sr_valid_q[i-1];
            sr_sel_d[i]   = sr_sel_q[i-1];
        end
    end

    // A bypassed result is still written and read, so both pointers advance
    // together and the count stays put.
    always_comb begin
        mem_d = mem_q;
        for (int n = 0; n < 2; n++) begin
            wr_ptr_d[n] = wr_ptr_q[n] + PW'(push_vec[n]);
            rd_ptr_d[n] = rd_ptr_q[n] + PW'(pop[n]);
            count_d[n]  = count_q[n] + CW'(push_vec[n]) - CW'(pop[n]);
            if (push_vec[n]) mem_d[n][wr_ptr_q[n]] = bus.dp_dout;
        end
    end

    always_comb begin
        rr_last_d = issue ? gnt_sel : rr_last_q;
        dp_sel_d  = issue ? gnt_sel : dp_sel_q;
        busy_d    = (|sr_valid_d) | (count_d[0] != '0) | (count_d[1] != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_valid_q <= '0;
            sr_sel_q   <= '0;
            for (int n = 0; n < 2; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                count_q[n]  <= '0;
            end
            rr_last_q <= 1'b1;
            dp_sel_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sr_valid_q <= sr_valid_d;
            sr_sel_q   <= sr_sel_d;
            for (int n = 0; n < 2; n++) begin
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                count_q[n]  <= count_d[n];
            end
            rr_last_q <= rr_last_d;
            dp_sel_q  <= dp_sel_d;
            busy_q    <= busy_d;
        end
    end

    // Storage carries no reset; occupancy is governed by the pointers and counts.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // The credit rule should make these unreachable.
    fifo0_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_vec[0] && (count_q[0] == CW'(DEPTH)) && !pop[0]));
    fifo1_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_vec[1] && (count_q[1] == CW'(DEPTH)) && !pop[1]));

endmodule

// File: tb/tb_conv_mask_sched.sv
module tb_conv_mask_sched;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_en = 1'b1;
    int checks = 0;
    int failures = 0;

    conv_mask_sched_if #(.DW(DW)) bus ();

    conv_mask_sched #(.DW(DW), .LAT(3), .DEPTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg_en (cfg_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Requester operands: tag nibble A / 5 plus a 12-bit sequence number.
    // Datapath model: three-stage identity pipeline, result LAT=3 cycles after issue.
    logic [11:0]   seq0 = '0;
    logic [11:0]   seq1 = '0;
    logic [DW-1:0] st1 = 16'hDEAD;
    logic [DW-1:0] st2 = 16'hDEAD;
    logic [DW-1:0] st3 = 16'hDEAD;

    always @(posedge clk) begin
        if (!rst_n) begin
            seq0 <= '0;
            seq1 <= '0;
        end else begin
            if (bus.req0_valid && bus.req0_ready) seq0 <= seq0 + 12'd1;
            if (bus.req1_valid && bus.req1_ready) seq1 <= seq1 + 12'd1;
        end
        st1 <= bus.dp_en ? (bus.dp_sel ? {4'h5, seq1} : {4'hA, seq0}) : 16'hDEAD;
        st2 <= st1;
        st3 <= st2;
    end
    assign bus.dp_dout = st3;

    logic [DW-1:0] exp_d;
    logic          exp_b;
    int            n0;
    int            n1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        cfg_en = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready got=%b exp=0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready got=%b exp=0", bus.req1_ready); end
        checks++; if (bus.dp_en !== 1'b0) begin failures++; $display("FAIL reset_dp_en got=%b exp=0", bus.dp_en); end
        checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b%b exp=00", bus.out1_valid, bus.out0_valid); end
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.dp_sel !== 1'b0) begin failures++; $display("FAIL reset_dp_sel got=%b exp=0", bus.dp_sel); end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            bus.req0_valid = (k < 4);
            bus.out0_ready = 1'b1;
            #1;
            checks++; if (bus.dp_en !== (k < 4)) begin failures++; $display("FAIL single_dp_en k=%0d got=%b exp=%b", k, bus.dp_en, (k < 4)); end
            checks++; if (bus.dp_sel !== 1'b0) begin failures++; $display("FAIL single_dp_sel k=%0d got=%b exp=0", k, bus.dp_sel); end
            exp_b = (k >= 3 && k <= 6);
            checks++; if (bus.out0_valid !== exp_b) begin failures++; $display("FAIL single_out0_valid k=%0d got=%b exp=%b", k, bus.out0_valid, exp_b); end
            if (exp_b) begin
                exp_d = 16'hA000 + 16'(k - 3);
                checks++; if (bus.out0_data !== exp_d) begin failures++; $display("FAIL single_out0_data k=%0d got=%h exp=%h", k, bus.out0_data, exp_d); end
            end
            exp_b = (k >= 1 && k <= 6);
            checks++; if (bus.busy !== exp_b) begin failures++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, bus.busy, exp_b); end
            tick();
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            bus.req0_valid = (k < 8);
            bus.req1_valid = (k < 8);
            bus.out0_ready = 1'b1;
            bus.out1_ready = 1'b1;
            #1;
            checks++; if (bus.dp_en !== (k < 8)) begin failures++; $display("FAIL cont_dp_en k=%0d got=%b exp=%b", k, bus.dp_en, (k < 8)); end
            if (k < 8) begin
                exp_b = (k % 2 == 1);
                checks++; if (bus.dp_sel !== exp_b) begin failures++; $display("FAIL cont_dp_sel k=%0d got=%b exp=%b", k, bus.dp_sel, exp_b); end
                checks++; if (bus.req1_ready !== exp_b || bus.req0_ready !== !exp_b) begin failures++; $display("FAIL cont_ready k=%0d got=%b%b exp=%b%b", k, bus.req1_ready, bus.req0_ready, exp_b, !exp_b); end
            end
            exp_b = (k >= 3 && k <= 9 && k % 2 == 1);
            checks++; if (bus.out0_valid !== exp_b) begin failures++; $display("FAIL cont_out0_valid k=%0d got=%b exp=%b", k, bus.out0_valid, exp_b); end
            if (exp_b) begin
                exp_d = 16'hA000 + 16'((k - 3) / 2);
                checks++; if (bus.out0_data !== exp_d) begin failures++; $display("FAIL cont_out0_data k=%0d got=%h exp=%h", k, bus.out0_data, exp_d); end
            end
            exp_b = (k >= 4 && k <= 10 && k % 2 == 0);
            checks++; if (bus.out1_valid !== exp_b) begin failures++; $display("FAIL cont_out1_valid k=%0d got=%b exp=%b", k, bus.out1_valid, exp_b); end
            if (exp_b) begin
                exp_d = 16'h5000 + 16'((k - 4) / 2);
                checks++; if (bus.out1_data !== exp_d) begin failures++; $display("FAIL cont_out1_data k=%0d got=%h exp=%h", k, bus.out1_data, exp_d); end
            end
            if (k == 12) begin
                checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cont_busy_idle got=%b exp=0", bus.busy); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k <= 15; k++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            bus.out0_ready = 1'b1;
            bus.out1_ready = 1'b0;
            #1;
            exp_b = (k < 8 && k % 2 == 1);
            checks++; if (bus.dp_en !== 1'b1) begin failures++; $display("FAIL bp_dp_en k=%0d got=%b exp=1", k, bus.dp_en); end
            checks++; if (bus.req1_ready !== exp_b || bus.req0_ready !== !exp_b) begin failures++; $display("FAIL bp_ready k=%0d got=%b%b exp=%b%b", k, bus.req1_ready, bus.req0_ready, exp_b, !exp_b); end
            checks++; if (bus.out1_valid !== (k >= 4)) begin failures++; $display("FAIL bp_out1_valid k=%0d got=%b exp=%b", k, bus.out1_valid, (k >= 4)); end
            if (k >= 4) begin
                checks++; if (bus.out1_data !== 16'h5000) begin failures++; $display("FAIL bp_out1_head k=%0d got=%h exp=5000", k, bus.out1_data); end
            end
            tick();
        end
        n1 = 0;
        for (int k = 16; k <= 31; k++) begin
            bus.req0_valid = (k < 24);
            bus.req1_valid = (k < 24);
            bus.out0_ready = 1'b1;
            bus.out1_ready = 1'b1;
            #1;
            if (k == 16) begin
                checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL bp_resume_early got=%b exp=0", bus.req1_ready); end
            end
            if (k == 17) begin
                checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL bp_resume got=%b exp=1", bus.req1_ready); end
            end
            if (bus.out1_valid === 1'b1) begin
                exp_d = 16'h5000 + 16'(n1);
                checks++; if (bus.out1_data !== exp_d) begin failures++; $display("FAIL bp_out1_order k=%0d got=%h exp=%h", k, bus.out1_data, exp_d); end
                n1++;
            end
            tick();
        end
        checks++; if (n1 !== 8) begin failures++; $display("FAIL bp_out1_total got=%0d exp=8", n1); end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            bus.req0_valid = 1'b1;
            cfg_en = (k < 3);
            bus.out0_ready = (k >= 8);
            #1;
            checks++; if (bus.dp_en !== (k < 3) || bus.req0_ready !== (k < 3)) begin failures++; $display("FAIL frz_issue k=%0d got=%b%b exp=%b", k, bus.dp_en, bus.req0_ready, (k < 3)); end
            exp_b = (k >= 3 && k <= 10);
            checks++; if (bus.out0_valid !== exp_b) begin failures++; $display("FAIL frz_out0_valid k=%0d got=%b exp=%b", k, bus.out0_valid, exp_b); end
            if (exp_b) begin
                exp_d = (k <= 8) ? 16'hA000 : 16'hA000 + 16'(k - 8);
                checks++; if (bus.out0_data !== exp_d) begin failures++; $display("FAIL frz_out0_data k=%0d got=%h exp=%h", k, bus.out0_data, exp_d); end
            end
            exp_b = (k >= 1 && k <= 10);
            checks++; if (bus.busy !== exp_b) begin failures++; $display("FAIL frz_busy k=%0d got=%b exp=%b", k, bus.busy, exp_b); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            bus.req0_valid = (k < 4) || (k == 10);
            bus.req1_valid = (k == 10);
            bus.out0_ready = 1'b0;
            bus.out1_ready = 1'b0;
            rst_n = (k != 5);
            #1;
            if (k == 4) begin
                checks++; if (bus.out0_valid !== 1'b1 || bus.busy !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b%b exp=11", bus.out0_valid, bus.busy); end
            end
            if (k == 5) begin
                checks++; if (bus.out0_valid !== 1'b0 || bus.dp_en !== 1'b0) begin failures++; $display("FAIL rmid_hold got=%b%b exp=00", bus.out0_valid, bus.dp_en); end
            end
            if (k >= 6 && k <= 9) begin
                checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid k=%0d got=%b%b exp=00", k, bus.out1_valid, bus.out0_valid); end
                checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy k=%0d got=%b exp=0", k, bus.busy); end
            end
            if (k == 10) begin
                checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0 || bus.dp_sel !== 1'b0) begin failures++; $display("FAIL rmid_tie got=%b%b sel=%b exp=01 sel=0", bus.req1_ready, bus.req0_ready, bus.dp_sel); end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_near_full();
        do_reset();
        for (int k = 0; k <= 15; k++) begin
            bus.req1_valid = (k < 4) || (k == 7) || (k == 8);
            bus.out1_ready = (k == 7) || (k >= 11);
            #1;
            exp_b = (k < 4) || (k == 8);
            checks++; if (bus.dp_en !== exp_b || bus.req1_ready !== exp_b) begin failures++; $display("FAIL nf_issue k=%0d got=%b%b exp=%b", k, bus.dp_en, bus.req1_ready, exp_b); end
            exp_b = (k >= 3 && k <= 14);
            checks++; if (bus.out1_valid !== exp_b) begin failures++; $display("FAIL nf_out1_valid k=%0d got=%b exp=%b", k, bus.out1_valid, exp_b); end
            if (exp_b) begin
                if (k <= 7)       exp_d = 16'h5000;
                else if (k <= 11) exp_d = 16'h5001;
                else              exp_d = 16'h5002 + 16'(k - 12);
                checks++; if (bus.out1_data !== exp_d) begin failures++; $display("FAIL nf_out1_data k=%0d got=%h exp=%h", k, bus.out1_data, exp_d); end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_freeze();
        test_reset_mid();
        test_near_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
